conv_row_scheduler: RTL
=======================

# conv_row_scheduler

Frame-level sequencer for the 3x3 convolution engine. It walks an input image row band by row band: it fetches input rows from source memory into three rotating line buffers, pulses the engine's `start`, waits for its `done`, then advances the destination address and the row pointer by the configured stride. It sits between the host control registers and the `convolve` engine, and owns the source-memory read port and the line-buffer write port.

## Interface
Parameters:
- `ROW_W`, default 16: pixels per image row (columns fetched per row).
- `SRC_AW`, default 10: source memory address width.
- `DST_STEP`, default 2: destination address increment per output row, matching the engine's two writes per pass.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; sampled only in IDLE.
- `stride` in 2: 1 or 2; any other value is illegal.
- `img_rows` in 6: number of input rows.
- `src_base` in SRC_AW: source address of pixel (row 0, col 0).
- `dst_base` in 5: destination address of the first output row.
- `busy` out 1: high from the cycle after an accepted `start` until the cycle DONE is left.
- `frame_done` out 1: one-cycle pulse at frame end.
- `cfg_err` out 1: one-cycle pulse when `start` is rejected.
- `src_rd_en` out 1: source memory read strobe.
- `src_rd_addr` out SRC_AW: source read address.
- `lb_wr_en` out 1: line-buffer write strobe.
- `lb_sel` out 2: physical line buffer being written (0..2).
- `lb_col` out 4: column index being written (log2 ROW_W).
- `lb_top` out 2: physical buffer that holds the topmost row of the current band.
- `conv_start` out 1: one-cycle pulse to the engine.
- `conv_stride` out 2: stride latched at `start`.
- `conv_dest_addr` out 5: destination address for the current pass.
- `conv_done` in 1: engine completion pulse.

## Operation
- States: IDLE, FETCH, KICK, WAIT, ADVANCE, DONE.
- **IDLE → FETCH on `start`** when `stride` ∈ {1,2} and `img_rows` ≥ 3. On entry:
  - latch `stride`, `img_rows`, `src_base`, `dst_base`;
  - set row pointer r=0, `lb_top`=0, out_row=0;
  - fetch count = 3.
- **Illegal `start`** (`stride` 0 or 3, or `img_rows` < 3): pulse `cfg_err` for one cycle and stay in IDLE.
- **FETCH:**
  - For each new row k (0..fetch count−1), issue ROW_W consecutive reads with `src_rd_addr` = src_base + src_row·ROW_W + col.
  - Initial band: src_row = k. Later bands: src_row = r+3+k−stride.
  - Destination buffer: `lb_sel` = (lb_top+k) mod 3 on the initial fetch, (old lb_top+k) mod 3 on later fetches.
  - After the last read has been issued, wait one cycle for the write echo, then go to KICK.
- **KICK:** pulse `conv_start` for one cycle, then go to WAIT.
- **WAIT:** hold until `conv_done` = 1, then go to ADVANCE.
- **ADVANCE:**
  - out_row+1; `conv_dest_addr` += DST_STEP (mod 32, wraps).
  - If r+stride+3 > img_rows, go to DONE.
  - Otherwise: r += stride; `lb_top` = (lb_top+stride) mod 3; fetch count = stride; go to FETCH.
- **DONE:** pulse `frame_done` for one cycle, then return to IDLE.
- Output rows per frame = floor((img_rows−3)/stride)+1.
- A `conv_done` pulse arriving outside WAIT is ignored.
- A `start` pulse arriving outside IDLE is ignored (no error is flagged).
- Address arithmetic is modulo 2^SRC_AW; overflow is not flagged.

## Timing
- Reset values: state IDLE; all outputs 0, including `conv_stride`, `lb_top` and `conv_dest_addr`.
- All outputs are registered.
- `src_rd_en`/`src_rd_addr` assert the cycle after entry to FETCH.
- `lb_wr_en`/`lb_sel`/`lb_col` are the read strobes delayed by exactly 1 cycle (source read latency = 1).
- Initial fetch: 3·ROW_W read cycles, plus 1 echo cycle, plus 1 state-exit cycle.
- `conv_start` is high exactly one cycle. `conv_dest_addr`, `conv_stride` and `lb_top` are stable from that cycle until ADVANCE.
- ADVANCE lasts 1 cycle.
- `frame_done` is asserted in the DONE cycle; `busy` deasserts on the following cycle.
- An `rst_n` assertion mid-frame immediately forces IDLE and all outputs to 0. No partial frame is resumed.

## Configuration
- `CONV_SCHED_PERF_EN` defined:
  - adds output `perf_cycles` [15:0], counting `busy` cycles of the current frame (saturating at 0xFFFF);
  - the count is held after `frame_done` and cleared at the next accepted `start`.
- Not defined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- **Minimum frame:** stride=1, img_rows=3, src_base=0, dst_base=4, ROW_W=16.
  - 48 reads at addresses 0..47; lb_sel 0,1,2 in 16-cycle runs.
  - One `conv_start` with `conv_dest_addr`=4; engine `done` 5 cycles later → `frame_done`, 1 pass total.
- **Stride-1 rotation:** img_rows=5.
  - 3 passes, dest 4, 6, 8.
  - Second fetch reads row 3 (addr 48..63) into buffer 0; `lb_top`=1.
  - Third pass: row 4 into buffer 1, `lb_top`=2.
- **Stride-2 rotation:** img_rows=7.
  - 3 passes.
  - Second fetch reads rows 3 and 4 into buffers 0 and 1; `lb_top`=2.
  - img_rows=6 with stride 2 → 2 passes (floor rule).
- **Illegal configuration:** stride=0 or img_rows=2 → `cfg_err` pulse, `busy` stays 0, no reads issued. A `start` while `busy` is ignored.
- **Address wrap and stray done:** dst_base=31 with 2 passes → second `conv_dest_addr`=1. A stray `conv_done` during FETCH causes no state change.
- **Reset mid-frame:** `rst_n` low during WAIT → all outputs 0 in the same cycle. A fresh `start` after release runs a full frame from row 0.

Source files
------------

// File: rtl/conv_row_scheduler.sv
// rtl/conv_row_scheduler.sv - frame sequencer feeding rotating line buffers to the 3x3 conv engine
// Optional feature macro: CONV_SCHED_PERF_EN (adds perf_cycles busy-cycle counter output).
module conv_row_scheduler #(
  parameter int ROW_W    = 16,
  parameter int SRC_AW   = 10,
  parameter int DST_STEP = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                stride,
  input  logic [5:0]                img_rows,
  input  logic [SRC_AW-1:0]         src_base,
  input  logic [4:0]                dst_base,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      cfg_err,
  output logic                      src_rd_en,
  output logic [SRC_AW-1:0]         src_rd_addr,
  output logic                      lb_wr_en,
  output logic [1:0]                lb_sel,
  output logic [$clog2(ROW_W)-1:0]  lb_col,
  output logic [1:0]                lb_top,
  output logic                      conv_start,
  output logic [1:0]                conv_stride,
  output logic [4:0]                conv_dest_addr,
  input  logic                      conv_done
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [15:0]               perf_cycles
`endif
);

  localparam int CW = $clog2(ROW_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_KICK,
    S_WAIT,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [5:0]        r;          // topmost source row of the current band
  logic [5:0]        rows_q;     // latched image height
  logic [SRC_AW-1:0] row_addr;   // source address of column 0 of the row being fetched
  logic [1:0]        fetch_buf;  // buffer receiving the row being fetched
  logic [1:0]        fetch_cnt;  // rows to fetch in this FETCH visit
  logic [1:0]        rd_k;       // index of the row being fetched within this visit
  logic [CW-1:0]     col;        // next column to read
  logic              issuing;    // reads still to be issued in this FETCH visit
  logic [1:0]        rd_sel;     // buffer tag travelling with the current read
  logic [CW-1:0]     rd_col;     // column tag travelling with the current read

  logic              cfg_ok;
  logic              accept;
  logic              reject;
  logic              fetch_over;
  logic              last_pass;
  logic [2:0]        top_sum;
  logic [1:0]        top_nx;

  // Start qualification, band-end test and next buffer rotation.
  always_comb begin
    cfg_ok     = ((stride == 2'd1) || (stride == 2'd2)) && (img_rows >= 6'd3);
    accept     = (state == S_IDLE) && start && cfg_ok;
    reject     = (state == S_IDLE) && start && !cfg_ok;
    // Last read issued and its write echo already on the line-buffer port.
    fetch_over = !issuing && !src_rd_en;
    last_pass  = ({1'b0, r} + {5'b0, conv_stride} + 7'd3) > {1'b0, rows_q};
    top_sum    = {1'b0, lb_top} + {1'b0, conv_stride};
    top_nx     = (top_sum >= 3'd3) ? 2'(top_sum - 3'd3) : top_sum[1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (accept) state_nx = S_FETCH;
      S_FETCH:   if (fetch_over) state_nx = S_KICK;
      S_KICK:    state_nx = S_WAIT;
      S_WAIT:    if (conv_done) state_nx = S_ADVANCE;
      S_ADVANCE: state_nx = last_pass ? S_DONE : S_FETCH;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Registered outputs, fetch sequencing and band bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      cfg_err        <= 1'b0;
      src_rd_en      <= 1'b0;
      src_rd_addr    <= '0;
      lb_wr_en       <= 1'b0;
      lb_sel         <= 2'd0;
      lb_col         <= '0;
      lb_top         <= 2'd0;
      conv_start     <= 1'b0;
      conv_stride    <= 2'd0;
      conv_dest_addr <= 5'd0;
      r              <= 6'd0;
      rows_q         <= 6'd0;
      row_addr       <= '0;
      fetch_buf      <= 2'd0;
      fetch_cnt      <= 2'd0;
      rd_k           <= 2'd0;
      col            <= '0;
      issuing        <= 1'b0;
      rd_sel         <= 2'd0;
      rd_col         <= '0;
    end else begin
      busy       <= (state_nx != S_IDLE);
      frame_done <= (state_nx == S_DONE);
      conv_start <= (state_nx == S_KICK);
      cfg_err    <= reject;
      // Source read latency is one cycle: writes echo the reads.
      lb_wr_en   <= src_rd_en;
      lb_sel     <= rd_sel;
      lb_col     <= rd_col;
      src_rd_en  <= 1'b0;

      if (accept) begin
        conv_stride    <= stride;
        rows_q         <= img_rows;
        row_addr       <= src_base;
        conv_dest_addr <= dst_base;
        r              <= 6'd0;
        lb_top         <= 2'd0;
        fetch_buf      <= 2'd0;
        fetch_cnt      <= 2'd3;
        rd_k           <= 2'd0;
        col            <= '0;
        issuing        <= 1'b1;
      end

      // Rows are fetched in source order into buffers in rotation, so a
      // running row address and buffer index give row r+3+k-stride into
      // buffer (old lb_top+k) mod 3 without recomputing either.
      if (state == S_FETCH && issuing) begin
        src_rd_en   <= 1'b1;
        src_rd_addr <= row_addr + SRC_AW'(col);
        rd_sel      <= fetch_buf;
        rd_col      <= col;
        if (col == CW'(ROW_W - 1)) begin
          col       <= '0;
          row_addr  <= row_addr + SRC_AW'(ROW_W);
          fetch_buf <= (fetch_buf == 2'd2) ? 2'd0 : fetch_buf + 2'd1;
          if (rd_k == fetch_cnt - 2'd1) begin
            issuing <= 1'b0;
          end else begin
            rd_k <= rd_k + 2'd1;
          end
        end else begin
          col <= col + CW'(1);
        end
      end

      if (state == S_ADVANCE) begin
        conv_dest_addr <= conv_dest_addr + 5'(DST_STEP);
        if (!last_pass) begin
          r         <= r + {4'b0, conv_stride};
          lb_top    <= top_nx;
          fetch_cnt <= conv_stride;
          rd_k      <= 2'd0;
          col       <= '0;
          issuing   <= 1'b1;
        end
      end
    end
  end

`ifdef CONV_SCHED_PERF_EN
  // Saturating count of busy cycles, cleared by each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= 16'd0;
    end else if (accept) begin
      perf_cycles <= 16'd0;
    end else if (busy && (perf_cycles != 16'hFFFF)) begin
      perf_cycles <= perf_cycles + 16'd1;
    end
  end
`endif

endmodule
